// File: rtl/sdram_read.sv
// SDRAM read burst engine: one PRECHARGE-all / ACTIVE / burst-8 READ per arbiter grant,
// walking a frame of bursts and capturing the returned words for the display line FIFO.
module sdram_read #(
  parameter int unsigned CL      = 3,
  parameter logic [9:0]  COL_END = 10'd632,
  parameter logic [12:0] ROW_END = 13'd479,
  parameter logic [4:0]  READ    = 5'b1_0000,
  parameter logic [3:0]  NOP     = 4'b0111,
  parameter logic [3:0]  ACT     = 4'b0011,
  parameter logic [3:0]  RD      = 4'b0101,
  parameter logic [3:0]  PRE     = 4'b0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_trig,
  output logic        rd_req,
  input  logic        rd_en,
  input  logic [4:0]  state,
  output logic [3:0]  rd_cmd,
  output logic [12:0] rd_addr,
  input  logic [15:0] rd_dq,
  output logic [15:0] rd_data,
  output logic        rd_data_valid,
  output logic        flag_rd_end,
  input  logic        vsync_pos,
  output logic        rd_hold
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned ROW_W = 13;
  localparam int unsigned COL_W = 10;

  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ACT   = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_RD    = CNT_W'(5);
  localparam logic [CNT_W-1:0] CAP_FIRST = CNT_W'(6 + CL);
  localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(13 + CL);
  localparam logic [CNT_W-1:0] CMD_END   = CNT_W'(14 + CL);

  localparam logic [ROW_W-1:0] PRE_ALL_ADDR = 13'h0400;
  localparam logic [COL_W-1:0] BURST_LEN    = COL_W'(8);

  logic [CNT_W-1:0] cmd_cnt;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_nxt;
  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic             hold_nxt;
  logic             vsync_pend;
  logic             pend_nxt;
  logic [3:0]       cmd_nxt;
  logic [ROW_W-1:0] addr_nxt;

  logic in_read;
  logic burst_done;
  logic resync;
  logic capture;

  assign in_read    = (state == READ) && !rd_hold;
  assign burst_done = (cmd_cnt == CMD_END);
  assign capture    = (cmd_cnt >= CAP_FIRST) && (cmd_cnt <= CAP_LAST);
  // A frame resync waits for the burst in flight to finish so its words stay coherent.
  assign resync     = (vsync_pos || vsync_pend) && (burst_done || (cmd_cnt == '0));

  // Next frame position: advance after each burst, override on resync.
  always_comb begin
    row_nxt  = row;
    col_nxt  = col;
    hold_nxt = rd_hold;
    pend_nxt = vsync_pend;
    if (burst_done) begin
      if (col == COL_END) begin
        col_nxt = '0;
        if (row == ROW_END) begin
          row_nxt  = '0;
          hold_nxt = 1'b1;
        end else begin
          row_nxt = row + ROW_W'(1);
        end
      end else begin
        col_nxt = col + BURST_LEN;
      end
    end
    if (resync) begin
      row_nxt  = '0;
      col_nxt  = '0;
      hold_nxt = 1'b0;
      pend_nxt = 1'b0;
    end else if (vsync_pos) begin
      pend_nxt = 1'b1;
    end
  end

  // Command decode; registered so it reaches the pins one cycle after the count.
  always_comb begin
    cmd_nxt  = NOP;
    addr_nxt = row;
    case (cmd_cnt)
      CNT_PRE: begin
        cmd_nxt  = PRE;
        addr_nxt = PRE_ALL_ADDR;
      end
      CNT_ACT: begin
        cmd_nxt  = ACT;
        addr_nxt = row;
      end
      CNT_RD: begin
        cmd_nxt  = RD;
        addr_nxt = {3'b000, col};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt       <= '0;
      row           <= '0;
      col           <= '0;
      rd_hold       <= 1'b0;
      vsync_pend    <= 1'b0;
      rd_req        <= 1'b0;
      rd_cmd        <= NOP;
      rd_addr       <= '0;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      flag_rd_end   <= 1'b0;
    end else begin
      cmd_cnt     <= in_read ? cmd_cnt + CNT_W'(1) : '0;
      row         <= row_nxt;
      col         <= col_nxt;
      rd_hold     <= hold_nxt;
      vsync_pend  <= pend_nxt;
      rd_cmd      <= cmd_nxt;
      rd_addr     <= addr_nxt;
      flag_rd_end <= burst_done;

      if (rd_en) begin
        rd_req <= 1'b0;
      end else if ((state != READ) && rd_trig && !rd_hold) begin
        rd_req <= 1'b1;
      end

      if (capture) begin
        rd_data       <= rd_dq;
        rd_data_valid <= 1'b1;
      end else begin
        rd_data_valid <= 1'b0;
      end
    end
  end

endmodule
